// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: start accepted at edge E0; busy for WIDTH cycles; done pulses after edge E0+WIDTH.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset, overrides everything
//   start   in   1      request an operation (sampled only in IDLE)
//   a       in   WIDTH  minuend, captured when start is accepted
//   b       in   WIDTH  subtrahend, captured when start is accepted
//   bin     in   1      borrow-in, captured when start is accepted
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle pulse, diff/borrow just updated
//   diff    out  WIDTH  a - b - bin modulo 2^WIDTH, held until next completion
//   borrow  out  1      1 iff a < b + bin (unsigned)

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_nxt;

  // Single full-subtractor cell working on the current LSBs.
  always_comb begin
    d      = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand shift registers, borrow, bit counter, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          // Difference bits enter at the MSB so the first (LSB) bit ends
          // up at position 0 after WIDTH shifts.
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          // Publish only the complete word; res itself is never exposed.
          if (cnt == LAST) begin
            diff   <= {d, res[WIDTH-1:1]};
            borrow <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  logic       start4, bin4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;

  logic       start8, bin8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .bin    (bin4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .bin    (bin8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation; operands are scrambled right after acceptance.
  task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                     input logic binv, input logic [3:0] exp_d, input logic exp_b);
    int n;
    a4 = av; b4 = bv; bin4 = binv; start4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = ~av; b4 = ~bv; bin4 = ~binv;
    n = 0;
    while (busy4 && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd4);
    check({tag, "_done"}, 32'(done4), 32'd1);
    check({tag, "_diff"}, 32'(diff4), 32'(exp_d));
    check({tag, "_borrow"}, 32'(borrow4), 32'(exp_b));
    tick();
    check({tag, "_done_clear"}, 32'(done4), 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic binv);
    int n;
    logic [8:0] e;
    e = {1'b0, av} - {1'b0, bv} - {8'd0, binv};
    a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~av; b8 = ~bv;
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd8);
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_result"}, 32'({borrow8, diff8}), 32'(e));
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_diff4", 32'(diff4), 32'd0);
    check("rst_borrow4", 32'(borrow4), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_diff8", 32'(diff8), 32'd0);

    // Basic operation and latency
    op4("t1_9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

    // Underflow, then hold across idle cycles
    op4("t2_3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_diff", 32'(diff4), 32'hA);
      check("t2_hold_borrow", 32'(borrow4), 32'd1);
      check("t2_hold_busy", 32'(busy4), 32'd0);
    end

    // Borrow-in edge cases
    op4("t3_0m0b1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    op4("t3_5m5", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0);

    // start held high: no restart during SHIFT/DONE, operand changes ignored
    a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    tick();
    a4 = 4'd0; b4 = 4'd15;
    n = 0;
    while (busy4 && n < 20) begin
      n++;
      tick();
    end
    check("t4_busy_cycles", 32'(n), 32'd4);
    check("t4_done", 32'(done4), 32'd1);
    check("t4_diff", 32'(diff4), 32'd5);
    check("t4_borrow", 32'(borrow4), 32'd0);
    tick();
    check("t4_no_restart_busy", 32'(busy4), 32'd0);
    check("t4_done_clear", 32'(done4), 32'd0);
    tick();
    check("t4_second_accept", 32'(busy4), 32'd1);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      n++;
      tick();
    end
    check("t4_second_done", 32'(done4), 32'd1);
    check("t4_second_diff", 32'(diff4), 32'd1);
    check("t4_second_borrow", 32'(borrow4), 32'd1);
    tick();

    // Reset mid-operation aborts it
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy4), 32'd0);
    check("t5_done", 32'(done4), 32'd0);
    check("t5_diff", 32'(diff4), 32'd0);
    check("t5_borrow", 32'(borrow4), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_no_done", 32'(done4), 32'd0);
      check("t5_no_busy", 32'(busy4), 32'd0);
    end

    // WIDTH=8 directed and random
    op8("t6_255m1", 8'd255, 8'd1, 1'b0);
    check("t6_diff_254", 32'(diff8), 32'd254);
    op8("t6_0m255b1", 8'd0, 8'd255, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      op8("t6_rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
